// File: rtl/button_evt_pkg.sv
// Shared types for the button event block.
//   evt_code_e  : event codes as they appear in the queued event word
//   btn_state_e : per-channel button FSM states
//   pack_evt    : builds {code, index} for a queue entry (index up to MAX_IW bits)
package button_evt_pkg;

  typedef enum logic [1:0] {
    PRESS   = 2'd0,
    RELEASE = 2'd1,
    LONG    = 2'd2,
    REPEAT  = 2'd3
  } evt_code_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    HELD    = 2'd2
  } btn_state_e;

  localparam int NUM_CODES = 4;
  localparam int MAX_IW    = 4;

  function automatic logic [2+MAX_IW-1:0] pack_evt(input evt_code_e code,
                                                   input logic [MAX_IW-1:0] idx);
    return {code, idx};
  endfunction

endpackage

// File: rtl/button_event_one.sv
// One debounced channel: edge detector, press/hold FSM, hold counter in ms ticks,
// and four registered 1-cycle event pulses.
//   clock, reset : system clock, synchronous active-high reset
//   tick         : 1 ms strobe from the shared prescaler
//   level        : debounced switch level, 1 = pressed
//   press, release_evt, long_press, repeat_evt : registered event pulses
//
// state   | meaning
// IDLE    | button up, waiting for a rising edge
// PRESSED | button down, counting ticks toward the long-press event
// HELD    | long press already reported, emitting periodic repeats
module button_event_one
  import button_evt_pkg::*;
#(
  parameter int LONG_MS   = 1000,
  parameter int REPEAT_MS = 200
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic level,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt
);

  localparam int HOLD_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int HW       = $clog2(HOLD_MAX);
  localparam logic [HW-1:0] LONG_LAST   = HW'(LONG_MS - 1);
  localparam logic [HW-1:0] REPEAT_LAST = HW'(REPEAT_MS - 1);

  btn_state_e    state, state_nxt;
  logic          prev;
  logic [HW-1:0] hold, hold_nxt;
  logic          press_nxt, release_nxt, long_nxt, repeat_nxt;
  logic          rise, fall;

  assign rise = level & ~prev;
  assign fall = ~level & prev;

  // prev tracks the input during reset too, so a level already high at
  // reset release never looks like a rising edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      prev        <= level;
      hold        <= '0;
      press       <= 1'b0;
      release_evt <= 1'b0;
      long_press  <= 1'b0;
      repeat_evt  <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev        <= level;
      hold        <= hold_nxt;
      press       <= press_nxt;
      release_evt <= release_nxt;
      long_press  <= long_nxt;
      repeat_evt  <= repeat_nxt;
    end
  end

  // A falling edge always wins over a tick in the same cycle.
  always_comb begin
    state_nxt   = state;
    hold_nxt    = hold;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    long_nxt    = 1'b0;
    repeat_nxt  = 1'b0;
    unique case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = PRESSED;
          hold_nxt  = '0;
          press_nxt = 1'b1;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (tick) begin
          if (hold == LONG_LAST) begin
            state_nxt = HELD;
            hold_nxt  = '0;
            long_nxt  = 1'b1;
          end else begin
            hold_nxt = hold + 1'b1;
          end
        end
      end
      HELD: begin
        if (fall) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else if (tick) begin
          if (hold == REPEAT_LAST) begin
            hold_nxt   = '0;
            repeat_nxt = 1'b1;
          end else begin
            hold_nxt = hold + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/button_events.sv
// Turns debounced switch levels into per-channel event pulses and a queued
// event stream.
//   clock, reset       : system clock, synchronous active-high reset
//   switch_db          : debounced levels, 1 = pressed
//   press, release_evt, long_press, repeat_evt : per-channel 1-cycle pulses
//   evt_valid/evt_ready: queue head handshake
//   evt_data           : {code[1:0], index[IW-1:0]} of the queue head
//   evt_ovf            : sticky, an event was lost; ovf_clr clears it
module button_events
  import button_evt_pkg::*;
#(
  parameter int INPUTS     = 16,
  parameter int TICK_DIV   = 50000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int FIFO_DEPTH = 8,
  localparam int IW = (INPUTS > 1) ? $clog2(INPUTS) : 1,
  localparam int DW = 2 + IW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [INPUTS-1:0] switch_db,
  output logic [INPUTS-1:0] press,
  output logic [INPUTS-1:0] release_evt,
  output logic [INPUTS-1:0] long_press,
  output logic [INPUTS-1:0] repeat_evt,
  output logic              evt_valid,
  input  logic              evt_ready,
  output logic [DW-1:0]     evt_data,
  output logic              evt_ovf,
  input  logic              ovf_clr
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // ms prescaler
  logic [PW-1:0] pre_cnt;
  logic          tick;

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  always_ff @(posedge clock) begin
    if (reset || tick) pre_cnt <= '0;
    else               pre_cnt <= pre_cnt + 1'b1;
  end

  for (genvar g = 0; g < INPUTS; g++) begin : g_ch
    button_event_one #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS)
    ) u_ch (
      .clock      (clock),
      .reset      (reset),
      .tick       (tick),
      .level      (switch_db[g]),
      .press      (press[g]),
      .release_evt(release_evt[g]),
      .long_press (long_press[g]),
      .repeat_evt (repeat_evt[g])
    );
  end

  // Row index equals the event code.
  logic [NUM_CODES-1:0][INPUTS-1:0] pulses, pend, pend_nxt, push_mask;

  assign pulses = {repeat_evt, long_press, release_evt, press};

  // Priority arbiter: scan from the top so the last hit is the lowest code,
  // then the lowest index.
  logic            arb_found;
  evt_code_e       arb_code;
  logic [IW-1:0]   arb_idx;

  always_comb begin
    arb_found = 1'b0;
    arb_code  = PRESS;
    arb_idx   = '0;
    for (int c = NUM_CODES - 1; c >= 0; c--) begin
      for (int i = INPUTS - 1; i >= 0; i--) begin
        if (pend[c][i]) begin
          arb_found = 1'b1;
          arb_code  = evt_code_e'(2'(c));
          arb_idx   = IW'(i);
        end
      end
    end
  end

  logic [CW-1:0] count;
  logic          push, pop, lost;

  // Full is judged on the registered count: a pop in the same cycle does not
  // open a slot until the next cycle.
  assign push = arb_found && (count != CW'(FIFO_DEPTH));
  assign pop  = evt_valid && evt_ready;

  always_comb begin
    push_mask = '0;
    if (push) push_mask[arb_code][arb_idx] = 1'b1;
  end

  // A pulse landing on the bit being pushed this cycle is a fresh event and
  // stays pending; only a pulse on a bit that stays set is lost.
  assign pend_nxt = (pend & ~push_mask) | pulses;
  assign lost     = |(pulses & pend & ~push_mask);

  always_ff @(posedge clock) begin
    if (reset) begin
      pend    <= '0;
      evt_ovf <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (lost)         evt_ovf <= 1'b1;
      else if (ovf_clr) evt_ovf <= 1'b0;
    end
  end

  // Event FIFO
  logic [2+MAX_IW-1:0] packed_evt;
  logic [DW-1:0]       entry;
  logic [DW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;

  assign packed_evt = pack_evt(arb_code, MAX_IW'(arb_idx));
  assign entry      = {packed_evt[2+MAX_IW-1 -: 2], packed_evt[IW-1:0]};

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= entry;
  end

  assign evt_valid = (count != '0);
  // Storage is not reset, so the head is masked while the queue is empty.
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_button_events.sv
module tb_button_events;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] switch_db;
  logic [15:0] press, release_evt, long_press, repeat_evt;
  logic        evt_valid, evt_ready, evt_ovf, ovf_clr;
  logic [5:0]  evt_data;

  int n_checks = 0;
  int n_fail   = 0;

  button_events #(
    .INPUTS(16), .TICK_DIV(4), .LONG_MS(3), .REPEAT_MS(2), .FIFO_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset), .switch_db(switch_db),
    .press(press), .release_evt(release_evt), .long_press(long_press),
    .repeat_evt(repeat_evt), .evt_valid(evt_valid), .evt_ready(evt_ready),
    .evt_data(evt_data), .evt_ovf(evt_ovf), .ovf_clr(ovf_clr)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] ev(input int code, input int idx);
    logic [1:0] c;
    logic [3:0] i;
    c = 2'(code);
    i = 4'(idx);
    return {c, i};
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 16; k++) begin
      if (evt_valid) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic pop_one();
    evt_ready = 1'b1;
    step();
    evt_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] acc_p, acc_r;
    bit saw_valid;
    switch_db = 16'h0001; evt_ready = 1'b0; ovf_clr = 1'b0; reset = 1'b1;
    step(); step(); step();
    n_checks++;
    if ({press, release_evt, long_press, repeat_evt} !== 64'h0) begin
      n_fail++; $display("FAIL reset_pulses: got %h required 0", {press, release_evt, long_press, repeat_evt});
    end
    n_checks++;
    if ({evt_valid, evt_data, evt_ovf} !== 8'h0) begin
      n_fail++; $display("FAIL reset_queue: got valid=%b data=%h ovf=%b required all 0", evt_valid, evt_data, evt_ovf);
    end
    reset = 1'b0;
    acc_p = '0; acc_r = '0; saw_valid = 1'b0;
    for (int s = 0; s < 20; s++) begin
      step();
      acc_p |= press; acc_r |= release_evt; saw_valid |= evt_valid;
    end
    switch_db = 16'h0000;
    for (int s = 0; s < 8; s++) begin
      step();
      acc_p |= press; acc_r |= release_evt; saw_valid |= evt_valid;
    end
    n_checks++;
    if (acc_p !== 16'h0 || acc_r !== 16'h0) begin
      n_fail++; $display("FAIL held_at_reset_pulses: got press=%h release=%h required 0", acc_p, acc_r);
    end
    n_checks++;
    if (saw_valid !== 1'b0) begin
      n_fail++; $display("FAIL held_at_reset_events: got valid seen=%b required 0", saw_valid);
    end
  endtask

  task automatic test_press_release();
    bit ok;
    evt_ready = 1'b0;
    switch_db[3] = 1'b1;
    step();
    n_checks++;
    if (press !== 16'h0008) begin
      n_fail++; $display("FAIL press3_t1: got %h required 0008", press);
    end
    step();
    n_checks++;
    if (press !== 16'h0000) begin
      n_fail++; $display("FAIL press3_t2: got %h required 0000", press);
    end
    step(); step(); step();
    switch_db[3] = 1'b0;
    step();
    n_checks++;
    if (release_evt !== 16'h0008) begin
      n_fail++; $display("FAIL release3_t6: got %h required 0008", release_evt);
    end
    n_checks++;
    if (evt_valid !== 1'b1 || evt_data !== ev(0, 3)) begin
      n_fail++; $display("FAIL head_press3: got valid=%b data=%h required 1/%h", evt_valid, evt_data, ev(0, 3));
    end
    pop_one();
    wait_valid(ok);
    n_checks++;
    if (!ok || evt_data !== ev(1, 3)) begin
      n_fail++; $display("FAIL head_release3: got valid=%b data=%h required 1/%h", ok, evt_data, ev(1, 3));
    end
    pop_one();
    step(); step(); step();
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL empty_after_3: got valid=%b required 0", evt_valid);
    end
  endtask

  task automatic test_long_repeat();
    int n_long, n_rep, long_at, rep1, rep2;
    logic [15:0] acc;
    evt_ready = 1'b1;
    n_long = 0; n_rep = 0; long_at = -1; rep1 = -1; rep2 = -1;
    switch_db[5] = 1'b1;
    for (int s = 1; s <= 40; s++) begin
      step();
      if (long_press[5]) begin
        n_long++;
        if (long_at < 0) long_at = s;
      end
      if (repeat_evt[5]) begin
        n_rep++;
        if (rep1 < 0) rep1 = s;
        else if (rep2 < 0) rep2 = s;
      end
    end
    n_checks++;
    if (n_long != 1) begin
      n_fail++; $display("FAIL long5_count: got %0d required 1", n_long);
    end
    n_checks++;
    if (long_at - 1 < 9 || long_at - 1 > 12) begin
      n_fail++; $display("FAIL long5_delay: got %0d cycles required 9..12", long_at - 1);
    end
    n_checks++;
    if (rep1 - long_at != 8 || rep2 - rep1 != 8) begin
      n_fail++; $display("FAIL repeat5_period: got %0d,%0d required 8,8", rep1 - long_at, rep2 - rep1);
    end
    n_checks++;
    if (n_rep != 3) begin
      n_fail++; $display("FAIL repeat5_count: got %0d required 3", n_rep);
    end
    switch_db[5] = 1'b0;
    step();
    n_checks++;
    if (release_evt !== 16'h0020) begin
      n_fail++; $display("FAIL release5: got %h required 0020", release_evt);
    end
    acc = '0;
    for (int s = 0; s < 20; s++) begin
      step();
      acc |= long_press | repeat_evt;
    end
    n_checks++;
    if (acc !== 16'h0) begin
      n_fail++; $display("FAIL after_release5: got long|repeat=%h required 0", acc);
    end
    n_checks++;
    if (evt_valid !== 1'b0 || evt_ovf !== 1'b0) begin
      n_fail++; $display("FAIL drained5: got valid=%b ovf=%b required 0/0", evt_valid, evt_ovf);
    end
  endtask

  task automatic test_same_cycle();
    logic [5:0] got[$];
    evt_ready = 1'b1;
    got.delete();
    switch_db[7] = 1'b1; switch_db[2] = 1'b1;
    for (int s = 0; s < 6; s++) begin
      step();
      if (evt_valid && evt_ready) got.push_back(evt_data);
    end
    n_checks++;
    if (got.size() != 2) begin
      n_fail++; $display("FAIL order27_count: got %0d required 2", got.size());
    end else if (got[0] !== ev(0, 2) || got[1] !== ev(0, 7)) begin
      n_fail++; $display("FAIL order27: got %h,%h required %h,%h", got[0], got[1], ev(0, 2), ev(0, 7));
    end
    switch_db[7] = 1'b0; switch_db[2] = 1'b0;
    for (int s = 0; s < 10; s++) step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] got[$];
    logic [5:0] exp6[6];
    evt_ready = 1'b0;
    exp6 = '{ev(0, 8), ev(0, 9), ev(0, 10), ev(1, 8), ev(1, 9), ev(1, 10)};
    switch_db[10:8] = 3'b111;
    for (int s = 0; s < 4; s++) step();
    switch_db[10:8] = 3'b000;
    for (int s = 0; s < 8; s++) step();
    n_checks++;
    if (evt_valid !== 1'b1 || evt_data !== ev(0, 8)) begin
      n_fail++; $display("FAIL full_head: got valid=%b data=%h required 1/%h", evt_valid, evt_data, ev(0, 8));
    end
    step();
    n_checks++;
    if (evt_data !== ev(0, 8)) begin
      n_fail++; $display("FAIL head_stable: got %h required %h", evt_data, ev(0, 8));
    end
    evt_ready = 1'b1;
    got.delete();
    for (int s = 0; s < 14; s++) begin
      if (evt_valid && evt_ready) got.push_back(evt_data);
      step();
    end
    n_checks++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL b2b_count: got %0d required 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got[k] !== exp6[k]) begin
          n_fail++; $display("FAIL b2b_order[%0d]: got %h required %h", k, got[k], exp6[k]);
        end
      end
    end
    n_checks++;
    if (evt_ovf !== 1'b0 || evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end: got ovf=%b valid=%b required 0/0", evt_ovf, evt_valid);
    end
  endtask

  task automatic test_overflow();
    logic [5:0] got[$];
    logic [5:0] exp6[6];
    evt_ready = 1'b0;
    exp6 = '{ev(0, 11), ev(1, 11), ev(0, 0), ev(1, 0), ev(0, 0), ev(1, 0)};
    switch_db[11] = 1'b1;
    step(); step(); step();
    switch_db[11] = 1'b0;
    for (int s = 0; s < 4; s++) step();
    n_checks++;
    if (evt_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_before: got %b required 0", evt_ovf);
    end
    for (int k = 0; k < 3; k++) begin
      switch_db[0] = 1'b1;
      step();
      switch_db[0] = 1'b0;
      step();
    end
    for (int s = 0; s < 4; s++) step();
    n_checks++;
    if (evt_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_set: got %b required 1", evt_ovf);
    end
    evt_ready = 1'b1;
    got.delete();
    for (int s = 0; s < 14; s++) begin
      if (evt_valid && evt_ready) got.push_back(evt_data);
      step();
    end
    evt_ready = 1'b0;
    n_checks++;
    if (got.size() != 6) begin
      n_fail++; $display("FAIL ovf_count: got %0d required 6", got.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        n_checks++;
        if (got[k] !== exp6[k]) begin
          n_fail++; $display("FAIL ovf_order[%0d]: got %h required %h", k, got[k], exp6[k]);
        end
      end
    end
    n_checks++;
    if (evt_ovf !== 1'b1) begin
      n_fail++; $display("FAIL ovf_sticky: got %b required 1", evt_ovf);
    end
    ovf_clr = 1'b1;
    step();
    ovf_clr = 1'b0;
    n_checks++;
    if (evt_ovf !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr: got %b required 0", evt_ovf);
    end
  endtask

  task automatic test_mid_reset();
    logic [15:0] acc;
    bit saw_valid;
    evt_ready = 1'b0;
    switch_db[14] = 1'b1;
    for (int s = 0; s < 4; s++) step();
    n_checks++;
    if (evt_valid !== 1'b1) begin
      n_fail++; $display("FAIL mid_queued: got valid=%b required 1", evt_valid);
    end
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    n_checks++;
    if (evt_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_flushed: got valid=%b required 0", evt_valid);
    end
    acc = '0; saw_valid = 1'b0;
    for (int s = 0; s < 4; s++) begin
      step();
      acc |= press | release_evt; saw_valid |= evt_valid;
    end
    switch_db[14] = 1'b0;
    for (int s = 0; s < 6; s++) begin
      step();
      acc |= press | release_evt; saw_valid |= evt_valid;
    end
    n_checks++;
    if (acc !== 16'h0 || saw_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_after: got pulses=%h valid seen=%b required 0/0", acc, saw_valid);
    end
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_long_repeat();
    test_same_cycle();
    test_back_to_back();
    test_overflow();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
